ccff_bitstream_loader: RTL and testbench

//  Drives the configuration-chain (ccff) head of a tile column from a parallel word stream, one bit per shift.

---
 rtl/ccff_pkg.sv | 8 +
 rtl/ccff_word_serializer.sv | 50 +++++
 rtl/ccff_bitstream_loader.sv | 67 ++++++
 tb/tb_ccff_bitstream_loader.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/ccff_pkg.sv
// ccff_pkg: shared state encoding, default sentinel and counter sizing for the ccff loader
package ccff_pkg;
  typedef enum logic [1:0] {IDLE, SENT, LOAD, DONE} state_t;
  localparam logic [7:0] DEF_SENTINEL = 8'hA5;
  function automatic int cnt_w(input int chain_len, input int sent_w);
    return $clog2(chain_len + sent_w + 1);
  endfunction
endpackage

// File: rtl/ccff_word_serializer.sv
// ccff_word_serializer: word register feeding the chain MSB first, with last-word truncation
module ccff_word_serializer
  import ccff_pkg::*;
#(
  parameter int CHAIN_LEN = 1024,
  parameter int DATA_W = 8,
  parameter int CW = cnt_w(1024, 8)
)(
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              en,
  input  logic              clear,
  input  logic              shift,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              has_bit,
  output logic              bit_out
);
  localparam int LW = $clog2(DATA_W + 1);
  logic [DATA_W-1:0] wr;
  logic [LW-1:0] left;
  logic [CW-1:0] rem, used;
  logic accept;
  // rem counts chain bits still to be fetched, so the final word keeps only its top bits
  always_comb begin
    used = (rem < CW'(DATA_W)) ? rem : CW'(DATA_W);
    has_bit = left != '0;
    bit_out = wr[DATA_W-1];
    cfg_ready = en && rem != '0 && (left == '0 || (left == LW'(1) && shift));
    accept = cfg_valid && cfg_ready;
  end
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      wr <= '0;
      left <= '0;
      rem <= '0;
    end else if (clear) begin
      left <= '0;
      rem <= CW'(CHAIN_LEN);
    end else if (accept) begin
      wr <= cfg_data;
      left <= LW'(used);
      rem <= rem - used;
    end else if (shift) begin
      wr <= wr << 1;
      left <= left - LW'(1);
    end
  end
endmodule

// File: rtl/ccff_bitstream_loader.sv
// ccff_bitstream_loader: shifts sentinel + bitstream into a ccff chain and verifies the tail
module ccff_bitstream_loader
  import ccff_pkg::*;
#(
  parameter int CHAIN_LEN = 1024,
  parameter int DATA_W = 8,
  parameter int SENT_W = 8,
  parameter logic [SENT_W-1:0] SENTINEL = SENT_W'(DEF_SENTINEL)
)(
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              error
);
  localparam int CW = cnt_w(CHAIN_LEN, SENT_W);
  state_t state, nxt;
  logic [CW-1:0] g, sidx;
  logic [SENT_W-1:0] ssh;
  logic err, go, has_bit, bit_out, ld_shift, mis;
  // one sentinel bit select serves both the head mux (SENT) and the tail check (LOAD)
  always_comb begin
    go = start && (state == IDLE || state == DONE);
    busy = state == SENT || state == LOAD;
    done = state == DONE;
    error = done && err;
    ld_shift = state == LOAD && has_bit;
    ccff_shift_en = state == SENT || ld_shift;
    sidx = (state == SENT) ? CW'(SENT_W - 1) - g : CW'(CHAIN_LEN + SENT_W - 1) - g;
    ssh = SENTINEL >> sidx;
    ccff_head = (state == SENT) ? ssh[0] : ld_shift && bit_out;
    mis = ld_shift && g >= CW'(CHAIN_LEN) && ccff_tail != ssh[0];
    nxt = go ? SENT :
          (state == SENT && g == CW'(SENT_W - 1)) ? LOAD :
          (ld_shift && g == CW'(CHAIN_LEN + SENT_W - 1)) ? DONE : state;
  end
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state <= IDLE;
      g <= '0;
      err <= 1'b0;
    end else begin
      state <= nxt;
      g <= go ? '0 : g + CW'(ccff_shift_en);
      err <= go ? 1'b0 : err | mis;
    end
  end
  ccff_word_serializer #(.CHAIN_LEN(CHAIN_LEN), .DATA_W(DATA_W), .CW(CW)) u_ser (
    .prog_clk(prog_clk),
    .prog_reset(prog_reset),
    .en(busy),
    .clear(go),
    .shift(ld_shift),
    .cfg_data(cfg_data),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .has_bit(has_bit),
    .bit_out(bit_out)
  );
endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// tb_ccff_bitstream_loader: directed checks of the loader against a behavioural 20-bit chain
module tb_ccff_bitstream_loader;
  logic prog_clk = 1'b0, prog_reset = 1'b1, start = 1'b0, cfg_valid = 1'b0;
  logic [7:0] cfg_data = '0;
  logic cfg_ready, ccff_head, ccff_shift_en, ccff_tail, busy, done, error;
  logic [19:0] chain = '0;
  logic short_chain = 1'b0, stuck = 1'b0, clr = 1'b0;
  int shifts = 0, stalls = 0, accepts = 0, tests = 0, fails = 0;
  logic [7:0] words [3] = '{8'h12, 8'h34, 8'h56};

  ccff_bitstream_loader #(.CHAIN_LEN(20), .DATA_W(8), .SENT_W(8), .SENTINEL(8'hA5)) dut (
    .prog_clk(prog_clk),
    .prog_reset(prog_reset),
    .start(start),
    .cfg_data(cfg_data),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .ccff_head(ccff_head),
    .ccff_shift_en(ccff_shift_en),
    .ccff_tail(ccff_tail),
    .busy(busy),
    .done(done),
    .error(error)
  );

  always #5 prog_clk = ~prog_clk;

  assign ccff_tail = stuck ? 1'b0 : short_chain ? chain[18] : chain[19];

  always @(posedge prog_clk) begin
    if (ccff_shift_en) chain <= {chain[18:0], ccff_head};
    if (clr) begin
      shifts <= 0;
      stalls <= 0;
      accepts <= 0;
    end else begin
      shifts <= shifts + int'(ccff_shift_en);
      stalls <= stalls + int'(busy && !ccff_shift_en);
      accepts <= accepts + int'(cfg_valid && cfg_ready);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int k = 0;
    while (!cfg_ready && k < 200) begin
      @(negedge prog_clk);
      k++;
    end
    chk(tag, {31'd0, cfg_ready}, 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (!done && k < 200) begin
      @(negedge prog_clk);
      k++;
    end
    chk(tag, {31'd0, done}, 32'd1);
  endtask

  task automatic kick();
    @(negedge prog_clk);
    clr = 1'b1;
    start = 1'b1;
    @(negedge prog_clk);
    clr = 1'b0;
    start = 1'b0;
  endtask

  task automatic feed(input int gap, input bit poke);
    for (int w = 0; w < 3; w++) begin
      if (gap > 0) begin
        wait_ready("gap_ready");
        repeat (gap) @(negedge prog_clk);
      end
      cfg_data = words[w];
      cfg_valid = 1'b1;
      wait_ready("word_ready");
      if (poke && w == 1) start = 1'b1;
      @(negedge prog_clk);
      cfg_valid = 1'b0;
      start = 1'b0;
    end
  endtask

  task automatic run(input int gap, input bit poke, input string tag);
    kick();
    feed(gap, poke);
    wait_done(tag);
  endtask

  initial begin
    repeat (3) @(negedge prog_clk);
    chk("reset_outs", {26'd0, cfg_ready, ccff_head, ccff_shift_en, busy, done, error}, 32'd0);
    prog_reset = 1'b0;
    @(negedge prog_clk);
    chk("idle_outs", {26'd0, cfg_ready, ccff_head, ccff_shift_en, busy, done, error}, 32'd0);

    run(0, 1'b0, "t1_done");
    chk("t1_chain", {12'd0, chain}, 32'h12345);
    chk("t1_shifts", shifts, 28);
    chk("t1_stalls", stalls, 0);
    chk("t1_accepts", accepts, 3);
    chk("t1_error", {31'd0, error}, 32'd0);
    cfg_valid = 1'b1;
    repeat (2) @(negedge prog_clk);
    chk("done_ready", {31'd0, cfg_ready}, 32'd0);
    cfg_valid = 1'b0;
    chk("done_no_accept", accepts, 3);

    run(3, 1'b0, "t2_done");
    chk("t2_chain", {12'd0, chain}, 32'h12345);
    chk("t2_shifts", shifts, 28);
    chk("t2_stalls", stalls, 6);
    chk("t2_error", {31'd0, error}, 32'd0);

    short_chain = 1'b1;
    run(0, 1'b0, "t3_done");
    chk("t3_error", {31'd0, error}, 32'd1);
    short_chain = 1'b0;

    stuck = 1'b1;
    run(0, 1'b0, "t4_done");
    chk("t4_error", {31'd0, error}, 32'd1);
    stuck = 1'b0;
    kick();
    chk("t4_restart", {29'd0, busy, done, error}, 32'b100);
    feed(0, 1'b0);
    wait_done("t4_redone");
    chk("t4_clean_error", {31'd0, error}, 32'd0);
    chk("t4_chain", {12'd0, chain}, 32'h12345);

    kick();
    cfg_data = 8'h12;
    cfg_valid = 1'b1;
    for (int k = 0; k < 100 && shifts < 10; k++) @(negedge prog_clk);
    chk("t5_g10", shifts, 10);
    prog_reset = 1'b1;
    @(negedge prog_clk);
    prog_reset = 1'b0;
    cfg_valid = 1'b0;
    chk("t5_reset_outs", {26'd0, cfg_ready, ccff_head, ccff_shift_en, busy, done, error}, 32'd0);
    run(0, 1'b0, "t5_done");
    chk("t5_chain", {12'd0, chain}, 32'h12345);
    chk("t5_shifts", shifts, 28);
    chk("t5_error", {31'd0, error}, 32'd0);

    run(0, 1'b1, "t6_done");
    chk("t6_accepts", accepts, 3);
    chk("t6_shifts", shifts, 28);
    chk("t6_chain", {12'd0, chain}, 32'h12345);
    chk("t6_error", {31'd0, error}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
